// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, fetch state encoding, reset PC
// default, and the branch-offset helper used by next-PC computation.
package cpu_pkg;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    ISSUE = 2'd2
  } fetch_state_e;

  // Word offset from a 16-bit branch immediate, sign-extended to 32 bits.
  function automatic logic [31:0] br_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: jump target, taken branch target, or
// fall-through, in that priority order.
module next_pc_calc
  import cpu_pkg::*;
(
  input  logic [31:0] pc_plus4_i,
  input  logic [25:0] imm26_i,
  input  logic        branch_i,
  input  logic        branch_ne_i,
  input  logic        jump_i,
  input  logic        alu_zero_i,
  output logic [31:0] next_pc_o
);

  logic        taken;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;

  // beq and bne both asserted: either condition alone takes the branch.
  assign taken  = (branch_i & alu_zero_i) | (branch_ne_i & ~alu_zero_i);
  assign br_tgt = pc_plus4_i + br_offset(imm26_i[15:0]);
  assign j_tgt  = {pc_plus4_i[31:28], imm26_i, 2'b00};

  always_comb begin
    next_pc_o = pc_plus4_i;
    if (jump_i)     next_pc_o = j_tgt;
    else if (taken) next_pc_o = br_tgt;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, imem request/ready handshake and
// issue to decode. Optional perf counters under FETCH_PERF_EN.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            imem_ready,
  output logic [XLEN-1:0] instr,
  output logic [5:0]      opcode,
  output logic            instr_valid,
  input  logic            instr_ack,
  input  logic            branch,
  input  logic            branch_ne,
  input  logic            jump,
  input  logic            alu_zero,
  output logic [XLEN-1:0] pc,
`ifdef FETCH_PERF_EN
  output logic [31:0]     fetch_count,
  output logic [31:0]     stall_count,
`endif
  output logic [XLEN-1:0] pc_plus4
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            vld_q, vld_d;
  logic            req_q, req_d;
  // Address kept as a word index so the low two bits are zero by construction.
  logic [XLEN-3:0] addr_q, addr_d;
  logic [XLEN-1:0] next_pc;

  next_pc_calc u_npc (
    .pc_plus4_i  (pc_plus4),
    .imm26_i     (instr_q[25:0]),
    .branch_i    (branch),
    .branch_ne_i (branch_ne),
    .jump_i      (jump),
    .alu_zero_i  (alu_zero),
    .next_pc_o   (next_pc)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    vld_d   = vld_q;
    req_d   = req_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        state_d = REQ;
        req_d   = 1'b1;
        addr_d  = pc_q[XLEN-1:2];
      end
      REQ: begin
        if (imem_ready) begin
          instr_d = imem_rdata;
          vld_d   = 1'b1;
          req_d   = 1'b0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (instr_ack) begin
          pc_d    = next_pc;
          vld_d   = 1'b0;
          req_d   = 1'b1;
          addr_d  = next_pc[XLEN-1:2];
          state_d = REQ;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
        vld_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      vld_q   <= 1'b0;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC[XLEN-1:2];
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      vld_q   <= vld_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (state_q == ISSUE && instr_ack)   fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (state_q == REQ   && !imem_ready) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign stall_count = stall_cnt_q;
`endif

  assign imem_req    = req_q;
  assign imem_addr   = {addr_q, 2'b00};
  assign instr       = instr_q;
  assign opcode      = instr_q[31:26];
  assign instr_valid = vld_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios, then randomized handshake and
// control traffic against a transaction-level fetch model.
module tb_fetch_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        imem_ready = 1'b0;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic        instr_valid;
  logic        instr_ack = 1'b0;
  logic        branch = 1'b0, branch_ne = 1'b0, jump = 1'b0, alu_zero = 1'b0;
  logic [31:0] pc, pc_plus4;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count, stall_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .instr(instr), .opcode(opcode), .instr_valid(instr_valid),
    .instr_ack(instr_ack),
    .branch(branch), .branch_ne(branch_ne), .jump(jump), .alu_zero(alu_zero),
    .pc(pc),
`ifdef FETCH_PERF_EN
    .fetch_count(fetch_count), .stall_count(stall_count),
`endif
    .pc_plus4(pc_plus4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [31:0] w,
                                           input logic j, input logic b, input logic bn,
                                           input logic z);
    logic [31:0] p4;
    int          off;
    p4  = p + 32'd4;
    off = int'($signed(w[15:0])) * 4;
    if (j)                           return {p4[31:28], w[25:0], 2'b00};
    if ((b && z) || (bn && !z))      return p4 + 32'(off);
    return p4;
  endfunction

  // Wait for a request, return word, then ack with the given controls.
  task automatic fetch(input logic [31:0] word, input logic [31:0] exp_pc,
                       input logic j, input logic b, input logic bn, input logic z);
    int n = 0;
    while (!imem_req && n < 20) begin tick(); n++; end
    chk("req_wait", {31'd0, imem_req}, 32'd1);
    chk("req_addr", imem_addr, exp_pc);
    imem_ready = 1'b1; imem_rdata = word;
    tick();
    imem_ready = 1'b0;
    chk("valid", {31'd0, instr_valid}, 32'd1);
    chk("instr", instr, word);
    chk("opcode", {26'd0, opcode}, {26'd0, word[31:26]});
    chk("pc", pc, exp_pc);
    chk("pc_plus4", pc_plus4, exp_pc + 32'd4);
    jump = j; branch = b; branch_ne = bn; alu_zero = z; instr_ack = 1'b1;
    tick();
    jump = 0; branch = 0; branch_ne = 0; alu_zero = 0; instr_ack = 1'b0;
    chk("ack_req", {31'd0, imem_req}, 32'd1);
    chk("ack_valid", {31'd0, instr_valid}, 32'd0);
  endtask

  initial begin
    logic        m_idle, m_req, m_vld;
    logic [31:0] m_pc, m_instr, r;
    logic [31:0] m_stall, m_fetch;
    logic [5:0]  ops [8];
    ops = '{OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_LUI, OP_LW, OP_SW};

    // Reset release with zero-wait memory.
    rst = 1'b1; imem_ready = 1'b1; imem_rdata = 32'h2008_0005;
    tick(); tick();
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    rst = 1'b0;
    tick();
    chk("c1_req", {31'd0, imem_req}, 32'd1);
    chk("c1_addr", imem_addr, 32'h0);
    chk("c1_valid", {31'd0, instr_valid}, 32'd0);
    tick();
    chk("c2_valid", {31'd0, instr_valid}, 32'd1);
    chk("c2_opcode", {26'd0, opcode}, 32'h08);
    chk("c2_pc", pc, 32'h0);
    chk("c2_pc4", pc_plus4, 32'h4);
    imem_ready = 1'b0; instr_ack = 1'b1;
    tick();
    instr_ack = 1'b0;
    chk("seq_addr", imem_addr, 32'h4);

    // Memory stall in REQ.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_addr", imem_addr, 32'h4);
      chk("stall_valid", {31'd0, instr_valid}, 32'd0);
    end
`ifdef FETCH_PERF_EN
    chk("stall_count", stall_count, 32'd3);
    chk("fetch_count", fetch_count, 32'd1);
`endif
    fetch(32'h0800_0010, 32'h4, 1, 0, 0, 0);
    chk("j_0x40", imem_addr, 32'h40);

    // beq backward taken / not taken.
    fetch(32'h1022_FFFE, 32'h40, 0, 1, 0, 1);
    chk("beq_taken", imem_addr, 32'h3C);
    fetch(32'h0800_0010, 32'h3C, 1, 0, 0, 0);
    fetch(32'h1022_FFFE, 32'h40, 0, 1, 0, 0);
    chk("beq_nt", imem_addr, 32'h44);

    // Climb into the 0x1xxx_xxxx region, then bne and jump-over-branch.
    fetch(32'h0BFF_FFFF, 32'h44, 1, 0, 0, 0);
    chk("j_0fff", imem_addr, 32'h0FFF_FFFC);
    fetch(32'h0800_0004, 32'h0FFF_FFFC, 1, 0, 0, 0);
    chk("j_1000", imem_addr, 32'h1000_0010);
    fetch(32'h1443_0003, 32'h1000_0010, 0, 0, 1, 0);
    chk("bne_taken", imem_addr, 32'h1000_0020);
    fetch(32'h1000_FFFB, 32'h1000_0020, 0, 1, 0, 1);
    chk("beq_back", imem_addr, 32'h1000_0010);
    fetch(32'h0800_0100, 32'h1000_0010, 1, 1, 0, 1);
    chk("jump_wins", imem_addr, 32'h1000_0400);

    // Reset while requesting with memory ready.
    rst = 1'b1; imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    chk("mrst_instr", instr, 32'h0);
    chk("mrst_valid", {31'd0, instr_valid}, 32'd0);
    chk("mrst_pc", pc, 32'h0);
    chk("mrst_req", {31'd0, imem_req}, 32'd0);
    rst = 1'b0;
    tick();
    chk("late_ready_valid", {31'd0, instr_valid}, 32'd0);
    chk("late_ready_instr", instr, 32'h0);
    imem_ready = 1'b0;
    fetch(32'h1000_FFFE, 32'h0, 0, 1, 0, 1);
    chk("wrap_back", imem_addr, 32'hFFFF_FFFC);
    fetch(32'h0000_0000, 32'hFFFF_FFFC, 0, 0, 0, 0);
    chk("wrap_fwd", imem_addr, 32'h0);

    // Randomized traffic against the fetch model.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_idle = 1; m_req = 0; m_vld = 0; m_pc = 32'h0; m_instr = '0;
    m_stall = 0; m_fetch = 0;
    for (int c = 0; c < 3000; c++) begin
      r          = $urandom;
      imem_ready = ($urandom % 4) != 0;
      imem_rdata = {ops[$urandom % 8], r[25:0]};
      instr_ack  = ($urandom % 3) != 0;
      jump       = ($urandom % 6) == 0;
      branch     = $urandom % 2;
      branch_ne  = $urandom % 2;
      alu_zero   = $urandom % 2;
      tick();
      if (m_idle) begin
        m_idle = 0; m_req = 1;
      end else if (m_req) begin
        if (imem_ready) begin m_req = 0; m_vld = 1; m_instr = imem_rdata; end
        else m_stall++;
      end else if (m_vld && instr_ack) begin
        m_pc = ref_next(m_pc, m_instr, jump, branch, branch_ne, alu_zero);
        m_vld = 0; m_req = 1; m_fetch++;
      end
      chk("r_req", {31'd0, imem_req}, {31'd0, m_req});
      chk("r_valid", {31'd0, instr_valid}, {31'd0, m_vld});
      chk("r_pc", pc, m_pc);
      chk("r_addr_lsb", {30'd0, imem_addr[1:0]}, 32'd0);
      if (m_req) chk("r_addr", imem_addr, m_pc);
      if (m_vld) begin
        chk("r_instr", instr, m_instr);
        chk("r_pc4", pc_plus4, m_pc + 32'd4);
      end
`ifdef FETCH_PERF_EN
      chk("r_stall_cnt", stall_count, m_stall);
      chk("r_fetch_cnt", fetch_count, m_fetch);
`endif
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
